// File: rtl/axis_window_expander_if.sv
// AXI4-Stream bundle shared by the word input and the beat output of the
// window expander.
//   tdata  : payload
//   tvalid : source has a transfer pending
//   tready : sink can accept a transfer this cycle
//   tlast  : final beat of a window (driven on the output side only)
// The master modport belongs to the side that drives the data. The slave
// modport belongs to the side that consumes it.
interface axis_window_expander_if #(
  parameter int unsigned DATA_WIDTH = 128
) ();
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_window_expander.sv
// Window expander. It takes one wide AXI4-Stream word and replays it as a
// window of N beats. Only beat 0 carries the low FLAG_WIDTH flag bits. Later
// beats carry those bits as zero, so OR-accumulating the window downstream
// rebuilds the original word.
//   aclk, aresetn : clock (rising edge) and asynchronous active-low reset
//   cfg           : window length. N = (cfg == 0) ? 1 : cfg. Sampled only
//                   when a word is accepted.
//   s_axis        : word input (tdata/tvalid in, tready out)
//   m_axis        : beat output (tdata/tvalid/tlast out, tready in)
module axis_window_expander #(
  parameter int unsigned AXIS_TDATA_WIDTH = 128,
  parameter int unsigned FLAG_WIDTH       = 66,
  parameter int unsigned CFG_WIDTH        = 8
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [CFG_WIDTH-1:0]  cfg,
  axis_window_expander_if.slave  s_axis,
  axis_window_expander_if.master m_axis
);

  // Clears the flag field. A shift by the full width yields 0, so the mask
  // still covers FLAG_WIDTH == AXIS_TDATA_WIDTH.
  localparam logic [AXIS_TDATA_WIDTH-1:0] KEEP_MASK =
    {AXIS_TDATA_WIDTH{1'b1}} << FLAG_WIDTH;

  typedef enum logic {
    S_IDLE,
    S_EMIT
  } state_t;

  state_t                      state_q;
  logic [AXIS_TDATA_WIDTH-1:0] hold_q;
  logic [AXIS_TDATA_WIDTH-1:0] data_q;
  logic [CFG_WIDTH-1:0]        cnt_q;
  logic [CFG_WIDTH-1:0]        len_m1_q;
  logic                        valid_q;
  logic                        last_q;

  logic [CFG_WIDTH-1:0]        n_cfg;
  logic                        at_last;
  logic                        s_ready;
  logic                        s_fire;
  logic                        m_fire;

  always_comb begin
    n_cfg   = (cfg == '0) ? CFG_WIDTH'(1) : cfg;
    at_last = (cnt_q == len_m1_q);
    // In EMIT a new word is accepted only together with the final beat,
    // so consecutive windows have no idle cycle between them.
    s_ready = (state_q == S_IDLE) || (m_axis.tready && at_last);
    s_fire  = s_axis.tvalid && s_ready;
    m_fire  = valid_q && m_axis.tready;
  end

  assign s_axis.tready = s_ready;
  assign m_axis.tdata  = data_q;
  assign m_axis.tvalid = valid_q;
  assign m_axis.tlast  = last_q;

  // The output beat is registered and loaded one step ahead. When the
  // counter advances, data_q and last_q take the values for the next beat,
  // so the outputs stay fixed while the sink stalls.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q  <= S_IDLE;
      hold_q   <= '0;
      data_q   <= '0;
      cnt_q    <= '0;
      len_m1_q <= '0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (s_fire) begin
            hold_q   <= s_axis.tdata;
            data_q   <= s_axis.tdata;
            cnt_q    <= '0;
            len_m1_q <= n_cfg - CFG_WIDTH'(1);
            valid_q  <= 1'b1;
            last_q   <= (n_cfg == CFG_WIDTH'(1));
            state_q  <= S_EMIT;
          end
        end
        S_EMIT: begin
          if (s_fire) begin
            hold_q   <= s_axis.tdata;
            data_q   <= s_axis.tdata;
            cnt_q    <= '0;
            len_m1_q <= n_cfg - CFG_WIDTH'(1);
            valid_q  <= 1'b1;
            last_q   <= (n_cfg == CFG_WIDTH'(1));
          end else if (m_fire) begin
            if (at_last) begin
              valid_q <= 1'b0;
              last_q  <= 1'b0;
              state_q <= S_IDLE;
            end else begin
              cnt_q  <= cnt_q + CFG_WIDTH'(1);
              data_q <= hold_q & KEEP_MASK;
              last_q <= ((cnt_q + CFG_WIDTH'(1)) == len_m1_q);
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_window_expander.sv
module tb_axis_window_expander;

  localparam int unsigned W  = 128;
  localparam int unsigned FW = 66;

  typedef struct {
    logic [W-1:0] data;
    logic         last;
  } beat_t;

  logic         aclk;
  logic         aresetn;
  logic [7:0]   cfg;

  axis_window_expander_if #(.DATA_WIDTH(W)) s_if ();
  axis_window_expander_if #(.DATA_WIDTH(W)) m_if ();

  axis_window_expander #(
    .AXIS_TDATA_WIDTH(W),
    .FLAG_WIDTH      (FW),
    .CFG_WIDTH       (8)
  ) dut (
    .aclk   (aclk),
    .aresetn(aresetn),
    .cfg    (cfg),
    .s_axis (s_if.slave),
    .m_axis (m_if.master)
  );

  int unsigned  errors;
  int unsigned  checks;
  beat_t        exp_q[$];
  logic [W-1:0] word_q[$];
  logic [W-1:0] acc;
  logic [W-1:0] flag_bits;
  int unsigned  beats_seen;
  int unsigned  rdy_mode;
  int unsigned  pidx;
  logic         pat [7];

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Reference: an accepted word becomes N beats. Beat 0 is the word itself.
  // The other beats are the word with the flag field cleared. Only the final
  // beat has tlast set.
  task automatic model_push(input logic [W-1:0] w, input logic [7:0] c);
    int unsigned n;
    beat_t b;
    n = (c == 0) ? 1 : int'(c);
    for (int unsigned i = 0; i < n; i++) begin
      b.data = (i == 0) ? w : (w & ~flag_bits);
      b.last = (i == n - 1);
      exp_q.push_back(b);
    end
    word_q.push_back(w);
  endtask

  // Called at a negedge. It offers the word until the DUT accepts it and
  // returns at the negedge after acceptance.
  task automatic send(input logic [W-1:0] w, input logic [7:0] c);
    bit fire;
    int unsigned k;
    s_if.tvalid = 1'b1;
    s_if.tdata  = w;
    cfg         = c;
    fire        = 1'b0;
    k           = 0;
    while (!fire && k < 2000) begin
      #2;
      if (s_if.tready) begin
        fire = 1'b1;
        model_push(w, c);
      end
      @(negedge aclk);
      k++;
    end
    if (!fire) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got no acceptance expected acceptance within 2000 cycles");
    end
    s_if.tvalid = 1'b0;
    cfg         = 8'($urandom);
  endtask

  task automatic drain();
    int unsigned k;
    k = 0;
    while (exp_q.size() != 0 && k < 5000) begin
      @(negedge aclk);
      k++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d beats pending expected 0", exp_q.size());
    end
  endtask

  // Drives m_axis_tready each cycle: always high, random, or a fixed pattern.
  initial begin
    m_if.tready = 1'b1;
    forever begin
      @(negedge aclk);
      case (rdy_mode)
        0: m_if.tready = 1'b1;
        1: m_if.tready = ($urandom_range(0, 3) != 0);
        default: begin
          m_if.tready = (pidx < 7) ? pat[pidx] : 1'b1;
          pidx++;
        end
      endcase
    end
  end

  // Monitor and scoreboard.
  initial begin
    beat_t b;
    logic  exp_rdy;
    forever begin
      @(negedge aclk);
      #1;
      if (aresetn) begin
        chk("m_tvalid", W'(m_if.tvalid), W'(exp_q.size() != 0));
        exp_rdy = (exp_q.size() == 0) || (m_if.tready && exp_q.size() == 1);
        chk("s_tready", W'(s_if.tready), W'(exp_rdy));
        if (m_if.tvalid && exp_q.size() != 0) begin
          b = exp_q[0];
          chk("m_tdata", m_if.tdata, b.data);
          chk("m_tlast", W'(m_if.tlast), W'(b.last));
          if (m_if.tready) begin
            void'(exp_q.pop_front());
            beats_seen++;
            acc = acc | m_if.tdata;
            if (b.last && word_q.size() != 0) begin
              chk("window_or", acc, word_q.pop_front());
              acc = '0;
            end
          end
        end
      end
    end
  end

  initial begin
    logic [W-1:0] w;
    logic [7:0]   c;
    int unsigned  base;
    int unsigned  k;

    errors = 0; checks = 0; beats_seen = 0; acc = '0;
    rdy_mode = 0; pidx = 0;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    flag_bits = '0;
    for (int unsigned i = 0; i < FW; i++) flag_bits[i] = 1'b1;

    s_if.tdata = '0; s_if.tlast = 1'b0; s_if.tvalid = 1'b1; cfg = 8'd4;
    aresetn = 1'b1;
    #1 aresetn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge aclk);
      #1;
      chk("rst_m_tvalid", W'(m_if.tvalid), '0);
      chk("rst_m_tlast", W'(m_if.tlast), '0);
      chk("rst_m_tdata", m_if.tdata, '0);
    end
    s_if.tvalid = 1'b0;
    @(negedge aclk);
    aresetn = 1'b1;
    #1 chk("rst_s_tready", W'(s_if.tready), W'(1));
    @(negedge aclk);

    // A window of 4 with every flag bit set.
    send(128'hA5A5_A5A5_A5A5_A5A_3_FFFF_FFFF_FFFF_FFFF, 8'd4);
    drain();

    // cfg 0: five words back-to-back pass straight through.
    for (int i = 0; i < 5; i++) send({$urandom, $urandom, $urandom, $urandom}, 8'd0);
    drain();

    // Two windows of 3 with no bubble between them.
    send({$urandom, $urandom, $urandom, $urandom}, 8'd3);
    send({$urandom, $urandom, $urandom, $urandom}, 8'd3);
    drain();

    // Stalls on the output, and a cfg change in the middle of a window.
    rdy_mode = 2; pidx = 0;
    send({$urandom, $urandom, $urandom, $urandom}, 8'd3);
    cfg = 8'd8;
    drain();
    rdy_mode = 0;
    send({$urandom, $urandom, $urandom, $urandom}, 8'd8);
    drain();

    // Random words, window lengths and backpressure.
    rdy_mode = 1;
    for (int i = 0; i < 150; i++) begin
      c = ($urandom_range(0, 9) < 2) ? 8'($urandom_range(0, 1)) : 8'($urandom_range(2, 6));
      send({$urandom, $urandom, $urandom, $urandom}, c);
      if ($urandom_range(0, 2) == 0)
        repeat ($urandom_range(1, 3)) @(negedge aclk);
    end
    drain();
    rdy_mode = 0;
    @(negedge aclk);

    // Longest window. Reset arrives at beat 100 and discards the rest.
    base = beats_seen;
    w = {$urandom, $urandom, $urandom, $urandom};
    send(w, 8'd255);
    k = 0;
    while (beats_seen < base + 100 && k < 1000) begin
      @(negedge aclk);
      k++;
    end
    chk("beats_before_reset", W'(beats_seen - base), W'(100));
    #3 aresetn = 1'b0;
    #1;
    chk("mid_rst_m_tvalid", W'(m_if.tvalid), '0);
    chk("mid_rst_m_tlast", W'(m_if.tlast), '0);
    chk("mid_rst_m_tdata", m_if.tdata, '0);
    exp_q.delete();
    word_q.delete();
    acc = '0;
    @(negedge aclk);
    @(negedge aclk);
    aresetn = 1'b1;
    repeat (20) @(negedge aclk);

    // Full window of 255 beats.
    base = beats_seen;
    send(w, 8'd255);
    drain();
    chk("beats_255", W'(beats_seen - base), W'(255));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axis_window_expander.md
Name: axis_window_expander

Overview:
- Transmit-side counterpart of the window accumulator.
- Takes one wide AXI4-Stream word and replays it as a window of N output beats.
- Only the first beat carries the flag field (low FLAG_WIDTH bits); later beats carry it zeroed, so OR-accumulating the window on the far end reconstructs the original word exactly.
- Sits between a word source (DMA/FIFO) and the per-beat datapath feeding the accumulator; used for loopback and stimulus generation.

Parameters:
AXIS_TDATA_WIDTH, 128, width of s/m tdata.
FLAG_WIDTH, 66, number of low tdata bits that are OR-accumulated downstream (must be <= AXIS_TDATA_WIDTH).
CFG_WIDTH, 8, width of cfg and of the beat counter.

Ports:
aclk  input  1  clock, all logic on rising edge
aresetn  input  1  asynchronous active-low reset
cfg  input  CFG_WIDTH  window length; N = (cfg == 0) ? 1 : cfg beats per input word
s_axis_tdata  input  AXIS_TDATA_WIDTH  input word
s_axis_tvalid  input  1  input valid
s_axis_tready  output  1  input ready
m_axis_tdata  output  AXIS_TDATA_WIDTH  output beat
m_axis_tvalid  output  1  output valid
m_axis_tready  input  1  output ready
m_axis_tlast  output  1  high on final beat of each window

Behaviour:
- Reset (aresetn low, asynchronous): state IDLE, holding register 0, beat counter 0, latched length 0.
  - Outputs during and after reset: m_axis_tvalid 0, m_axis_tlast 0, m_axis_tdata 0, s_axis_tready 1 once released.
- Reset mid-window discards the window; no partial completion after release.
- Handshake: a transfer occurs on a cycle where valid and ready are both high. m_axis_tdata/m_axis_tlast are stable while m_axis_tvalid is high and m_axis_tready is low.
- States:
  - IDLE: s_axis_tready = 1, m_axis_tvalid = 0.
    - On s accept: latch tdata into holding register; latch N from cfg (cfg sampled only here); counter = 0; go EMIT.
    - Latency: the first output beat is valid on the cycle after acceptance.
  - EMIT: m_axis_tvalid = 1.
    - m_axis_tdata = holding register when counter == 0.
    - Otherwise m_axis_tdata = holding register with bits [FLAG_WIDTH-1:0] forced to 0.
    - m_axis_tlast = (counter == N-1).
    - On m transfer with counter < N-1: counter increments.
    - On m transfer with counter == N-1: window complete.
- Back-to-back: in EMIT, s_axis_tready = m_axis_tready AND (counter == N-1).
  - If s accept coincides with the last-beat transfer: latch the new word and N, counter = 0, stay EMIT. No idle bubble.
  - Otherwise, after the last-beat transfer, go IDLE.
  - s_axis_tready is combinational from m_axis_tready in EMIT only.
- N = 1 (cfg 0 or 1): pure pass-through with one cycle of registration. Every beat has tlast = 1 and full data including flags. Sustains 1 word/cycle under continuous ready.
- N = 255 (cfg max): counter reaches 254 and no wrap occurs. Counter width CFG_WIDTH suffices since N-1 <= 2^CFG_WIDTH - 2.
- A cfg change during EMIT has no effect on the current window; it applies at the next acceptance.
- m_axis_tready low stalls the counter; the beat is held indefinitely. No timeout.
- Throughput: exactly N output beats per input word, one per cycle when m_axis_tready is continuously high.

Test Plan:
- Reset: hold aresetn low, drive s_axis_tvalid=1 -> m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0 throughout; after release s_axis_tready=1.
- cfg=4, word 0xA5A5_..._3_FFFF_FFFF_FFFF_FFFF (all 66 flag bits set), m_axis_tready=1 -> 4 beats on consecutive cycles:
  - beat0 = full word;
  - beats1-3 = upper 62 bits only, low 66 bits 0;
  - tlast only on beat3;
  - the OR of the 4 beats equals the input word.
- cfg=0, 5 words offered back-to-back with m_axis_tready=1 -> 5 beats in 5 consecutive cycles, each tlast=1, data identical to inputs, s_axis_tready never drops.
- cfg=3, two words offered continuously -> 6 output beats with no gap; second word accepted on the same cycle as the first window's tlast transfer.
- cfg=3, m_axis_tready toggled 1,0,0,1,1,0,1 -> tdata/tlast frozen while stalled, exactly 3 transfers, s_axis_tready high only with the final transfer; cfg changed to 8 mid-window has no effect until the next word.
- cfg=255, one word -> exactly 255 beats, tlast on beat 254, counter never wraps; assert aresetn low at beat 100 -> m_axis_tvalid drops immediately (asynchronously), no further beats after release.
